video_pattern_gen: RTL

Source-domain video test-pattern generator producing an 8-bit luminance stream with vs/hs/de timing on isrc_clk. It is the transmitting end of the source video interface consumed by the frame-statistics and contrast-stretch path. It is used for bring-up and regression in place of the camera front end. Timing is parameterised, and the pattern is selected per frame.

---
 rtl/video_pattern_gen_pkg.sv | 22 ++
 rtl/video_pattern_gen_lfsr8.sv | 39 +++
 rtl/video_pattern_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared constants for the source-domain video pattern generator:
// pattern select codes, generator state encoding and the LFSR step function.
package video_pattern_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] PAT_RAMP    = 2'd0;
  localparam logic [1:0] PAT_CHECKER = 2'd1;
  localparam logic [1:0] PAT_CONST   = 2'd2;
  localparam logic [1:0] PAT_PRBS    = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/video_pattern_gen_lfsr8.sv
// 8-bit PRBS source for the pattern generator; load reseeds to 8'hFF and
// takes priority over step.
module lfsr8
  import video_pattern_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  // Next-state selection: reseed, advance or hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = LFSR_SEED;
    end else if (step) begin
      state_d = lfsr8_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern generator: parameterised vs/hs/de timing with a per-frame
// pattern. Define PATTERN_PRBS_EN to enable the PRBS pattern (code 3).
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic POLARITY = 1'b1
) (
  input  logic        isrc_clk,
  input  logic        isrc_rst_n,
  input  logic        ienable,
  input  logic [1:0]  ipattern,
  input  logic [7:0]  iconst,
  output logic [7:0]  odata,
  output logic        ovs,
  output logic        ohs,
  output logic        ode,
  output logic [15:0] oframe_cnt
);

  localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] HS_BEG  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END  = 16'(V_ACTIVE + V_FP + V_SYNC);

  state_e      state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [15:0] frame_q, frame_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  const_q, const_d;
  logic [7:0]  data_q, data_d;
  logic        de_q, de_d, vs_q, vs_d, hs_q, hs_d;

  logic        run_s, origin_s, line_end_s, frame_end_s, active_s;
  logic        hs_win_s, vs_win_s;
  logic [1:0]  pat_s;
  logic [7:0]  const_s, pix_s, lfsr_s;

  assign run_s       = (state_q == ST_RUN) && ienable;
  assign origin_s    = (hcnt_q == 16'd0) && (vcnt_q == 16'd0);
  assign line_end_s  = (hcnt_q == H_LAST);
  assign frame_end_s = line_end_s && (vcnt_q == V_LAST);
  assign active_s    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_win_s    = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
  assign vs_win_s    = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
  // Pixel (0,0) is emitted in the latching cycle, so it uses the live selects.
  assign pat_s       = origin_s ? ipattern : pat_q;
  assign const_s     = origin_s ? iconst : const_q;

`ifdef PATTERN_PRBS_EN
  logic lfsr_load_s, lfsr_step_s;
  // Reseed while idle/stopping and on the frame wrap so pixel (0,0) sees 8'hFF.
  assign lfsr_load_s = (state_q == ST_IDLE) || !ienable || frame_end_s;
  assign lfsr_step_s = run_s && active_s;

  lfsr8 u_lfsr8 (
    .clk   (isrc_clk),
    .rst_n (isrc_rst_n),
    .load  (lfsr_load_s),
    .step  (lfsr_step_s),
    .state (lfsr_s)
  );
`else
  assign lfsr_s = 8'h00;
`endif

  // Active-area pixel value for the selected pattern.
  always_comb begin
    pix_s = 8'h00;
    case (pat_s)
      PAT_RAMP:    pix_s = hcnt_q[7:0];
      PAT_CHECKER: pix_s = (hcnt_q[3] ^ vcnt_q[3]) ? 8'hFF : 8'h00;
      PAT_CONST:   pix_s = const_s;
      PAT_PRBS:    pix_s = lfsr_s;
      default:     pix_s = 8'h00;
    endcase
  end

  // FSM next state, raster counters and next output values.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    pat_d   = pat_q;
    const_d = const_q;
    data_d  = 8'h00;
    de_d    = 1'b0;
    vs_d    = ~POLARITY;
    hs_d    = ~POLARITY;
    if (state_q == ST_IDLE) begin
      hcnt_d = 16'd0;
      vcnt_d = 16'd0;
      if (ienable) state_d = ST_RUN;
      else         state_d = ST_IDLE;
    end else if (!run_s) begin
      state_d = ST_IDLE;
      hcnt_d  = 16'd0;
      vcnt_d  = 16'd0;
    end else begin
      if (origin_s) begin
        pat_d   = ipattern;
        const_d = iconst;
      end else begin
        pat_d   = pat_q;
        const_d = const_q;
      end
      data_d = active_s ? pix_s : 8'h00;
      de_d   = active_s;
      hs_d   = hs_win_s ? POLARITY : ~POLARITY;
      vs_d   = vs_win_s ? POLARITY : ~POLARITY;
      if (frame_end_s) begin
        hcnt_d  = 16'd0;
        vcnt_d  = 16'd0;
        frame_d = frame_q + 16'd1;
      end else if (line_end_s) begin
        hcnt_d = 16'd0;
        vcnt_d = vcnt_q + 16'd1;
      end else begin
        hcnt_d = hcnt_q + 16'd1;
      end
    end
  end

  // FSM state, counters, frame latches and registered outputs.
  always_ff @(posedge isrc_clk or negedge isrc_rst_n) begin
    if (!isrc_rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= 16'd0;
      vcnt_q  <= 16'd0;
      frame_q <= 16'd0;
      pat_q   <= PAT_RAMP;
      const_q <= 8'h00;
      data_q  <= 8'h00;
      de_q    <= 1'b0;
      vs_q    <= ~POLARITY;
      hs_q    <= ~POLARITY;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
      const_q <= const_d;
      data_q  <= data_d;
      de_q    <= de_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
    end
  end

  assign odata      = data_q;
  assign ode        = de_q;
  assign ovs        = vs_q;
  assign ohs        = hs_q;
  assign oframe_cnt = frame_q;

endmodule
